instr_mem_pipe: RTL

- Parametrised, synchronous-read instruction memory for the 5-stage RV32I pipeline.
- Serves the IF stage through a valid/ready fetch handshake with a one-entry output register, so IF can stall and flush.
- Adds a byte-strobed program-load write port, used by the bench or a boot loader to fill the memory.
- Byte-addressed and little-endian: byte at addr is bits [7:0] of the returned word.

---
 rtl/rv_pkg.sv | 23 ++
 rtl/imem_ram.sv | 40 ++++
 rtl/instr_mem_pipe.sv | 110 +++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I definitions used by fetch, decode and the instruction memory.
package rv_pkg;

    localparam int INSTR_W = 32;

    // addi x0, x0, 0 -- the canonical bubble
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    function automatic logic [6:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/imem_ram.sv
// DEPTH_WORDS x 32 instruction RAM: registered read, byte-strobed write,
// read-before-write when both touch the same word in one cycle.
// Stored as four byte lanes so each lane maps onto a byte-wide block RAM.
module imem_ram
    import rv_pkg::*;
#(
    parameter  int DEPTH_WORDS = 256,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic               clk,
    input  logic               rd_en,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [INSTR_W-1:0] rd_data,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic [3:0]         wr_be
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] rd_byte_reg;

            // Old contents are sampled before the write lands (read-before-write)
            always_ff @(posedge clk) begin
                if (rd_en) begin
                    rd_byte_reg <= lane_mem[rd_idx];
                end
                if (wr_en && wr_be[gi]) begin
                    lane_mem[wr_idx] <= wr_data[8*gi +: 8];
                end
            end

            assign rd_data[8*gi +: 8] = rd_byte_reg;
        end
    endgenerate

endmodule

// File: rtl/instr_mem_pipe.sv
// Instruction memory for the IF stage: valid/ready fetch with a one-entry
// response register, flush, alignment/range faults and a program-load port.
module instr_mem_pipe
    import rv_pkg::*;
#(
    parameter int                 DEPTH_WORDS = 256,
    parameter int                 ADDR_W      = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR   = rv_pkg::NOP_INSTR,
    parameter bit                 CHECK_ALIGN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [INSTR_W-1:0] rsp_instr,
    output logic               rsp_fault,
    output logic [ADDR_W-1:0]  rsp_addr,
    input  logic               flush,
    input  logic               ld_en,
    input  logic [ADDR_W-1:0]  ld_addr,
    input  logic [INSTR_W-1:0] ld_data,
    input  logic [3:0]         ld_be
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    // Address bits that must be zero for an in-range access. If the address
    // is no wider than the memory the shift wraps to zero and the mask is empty.
    localparam logic [ADDR_W-1:0] HI_MASK =
        ~((ADDR_W'(1) << (IDX_W + 2)) - ADDR_W'(1));

    logic               rsp_valid_reg, rsp_valid_next;
    logic               rsp_fault_reg, rsp_fault_next;
    logic [ADDR_W-1:0]  rsp_addr_reg,  rsp_addr_next;

    logic               req_oor;
    logic               req_mis;
    logic               req_fault;
    logic               accept;
    logic               ram_rd_en;
    logic               ram_wr_en;
    logic [INSTR_W-1:0] ram_rd_data;

    assign req_ready = !rsp_valid_reg || rsp_ready;
    assign accept    = req_valid && req_ready && !flush;

    assign req_oor   = |(req_addr & HI_MASK);
    assign req_mis   = CHECK_ALIGN && (req_addr[1:0] != 2'b00);
    assign req_fault = req_oor || req_mis;

    // Faulting fetches never touch the array; out-of-range loads are dropped.
    // A read and a write in the same cycle are both served in one access.
    assign ram_rd_en = accept && !req_fault;
    assign ram_wr_en = ld_en && !(|(ld_addr & HI_MASK));

    imem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk     (clk),
        .rd_en   (ram_rd_en),
        .rd_idx  (req_addr[IDX_W+1:2]),
        .rd_data (ram_rd_data),
        .wr_en   (ram_wr_en),
        .wr_idx  (ld_addr[IDX_W+1:2]),
        .wr_data (ld_data),
        .wr_be   (ld_be)
    );

    // Response register next state: flush beats accept beats retire; else hold
    always_comb begin
        rsp_valid_next = rsp_valid_reg;
        rsp_fault_next = rsp_fault_reg;
        rsp_addr_next  = rsp_addr_reg;
        if (flush) begin
            rsp_valid_next = 1'b0;
            rsp_fault_next = 1'b0;
        end else if (accept) begin
            rsp_valid_next = 1'b1;
            rsp_fault_next = req_fault;
            rsp_addr_next  = req_addr;
        end else if (rsp_ready) begin
            rsp_valid_next = 1'b0;
            rsp_fault_next = 1'b0;
        end
    end

    // Response register; reset drops any held response immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg <= 1'b0;
            rsp_fault_reg <= 1'b0;
            rsp_addr_reg  <= '0;
        end else begin
            rsp_valid_reg <= rsp_valid_next;
            rsp_fault_reg <= rsp_fault_next;
            rsp_addr_reg  <= rsp_addr_next;
        end
    end

    // RAM output only holds meaning for a valid, non-faulting response.
    // It is stable during a stall because no read is enabled then.
    assign rsp_valid = rsp_valid_reg;
    assign rsp_fault = rsp_fault_reg;
    assign rsp_addr  = rsp_addr_reg;
    assign rsp_instr = (rsp_valid_reg && !rsp_fault_reg) ? ram_rd_data : NOP_INSTR;

endmodule
